// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg: shared line/beat geometry, types and adaptor state encoding
package cacheline_adaptor_pkg;
  localparam int S_LINE   = 256;
  localparam int S_BURST  = 64;
  localparam int S_BURSTS = S_LINE / S_BURST;
  localparam int S_OFFSET = 5;
  localparam int S_CNT    = $clog2(S_BURSTS);
  typedef logic [S_LINE-1:0]  line_t;
  typedef logic [S_BURST-1:0] burst_t;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/cacheline_adaptor_if.sv
// cacheline_adaptor_if: cache-side line port and memory-side burst port bundled together
interface cacheline_adaptor_if;
  import cacheline_adaptor_pkg::*;
  line_t       line_i;
  line_t       line_o;
  logic [31:0] address_i;
  logic        read_i;
  logic        write_i;
  logic        resp_o;
  burst_t      burst_i;
  burst_t      burst_o;
  logic [31:0] address_o;
  logic        read_o;
  logic        write_o;
  logic        resp_i;
  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: assembles/serializes a cache line over S_BURSTS memory beats
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input logic clk,
  input logic rst,
  cacheline_adaptor_if.slave bus
);
  state_t           state, state_n;
  logic [S_CNT-1:0] cnt;
  line_t            wbuf, line_q;
  logic [31:0]      addr_q;
  logic             beat;
  always_comb begin
    beat        = bus.resp_i && (state == READ || state == WRITE);
    state_n     = state == IDLE ? (bus.read_i ? READ : bus.write_i ? WRITE : IDLE) :
                  state == DONE ? IDLE :
                  (beat && cnt == S_CNT'(S_BURSTS - 1)) ? DONE : state;
    bus.read_o    = state == READ;
    bus.write_o   = state == WRITE;
    bus.resp_o    = state == DONE;
    bus.burst_o   = wbuf[cnt*S_BURST +: S_BURST];
    bus.line_o    = line_q;
    bus.address_o = addr_q;
  end
  // cnt wraps to zero on the final beat, which is exactly the DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      wbuf   <= '0;
      line_q <= '0;
      addr_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && (bus.read_i || bus.write_i)) begin
        addr_q <= bus.address_i & ~((32'd1 << S_OFFSET) - 32'd1);
        cnt    <= '0;
        if (!bus.read_i) wbuf <= bus.line_i;
      end
      if (beat) cnt <= cnt + 1'b1;
      if (beat && state == READ) line_q[cnt*S_BURST +: S_BURST] <= bus.burst_i;
    end
  end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed checks of read, gapped read, write, held request, reset and priority
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  cacheline_adaptor_if bus();
  cacheline_adaptor dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic [63:0] v);
    bus.resp_i  = 1'b1;
    bus.burst_i = v;
    tick();
  endtask
  logic [63:0] b1[4], b2[4], b3[4], d[4];
  logic [6:0]  gap_pat;
  initial begin
    b1 = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444};
    b2 = '{64'h5555555555555555, 64'h6666666666666666, 64'h7777777777777777, 64'h8888888888888888};
    b3 = '{64'h9999999999999999, 64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB, 64'hCCCCCCCCCCCCCCCC};
    d  = '{64'hD0D0D0D0D0D0D0D0, 64'hD1D1D1D1D1D1D1D1, 64'hD2D2D2D2D2D2D2D2, 64'hD3D3D3D3D3D3D3D3};
    gap_pat = 7'b1011001;
    bus.line_i = '0; bus.address_i = '0; bus.read_i = 0; bus.write_i = 0;
    bus.burst_i = '0; bus.resp_i = 0;
    tick(); tick();
    chk("rst_read_o", 256'(bus.read_o), 256'd0);
    chk("rst_write_o", 256'(bus.write_o), 256'd0);
    chk("rst_resp_o", 256'(bus.resp_o), 256'd0);
    chk("rst_address_o", 256'(bus.address_o), 256'd0);
    chk("rst_line_o", bus.line_o, 256'd0);
    chk("rst_burst_o", 256'(bus.burst_o), 256'd0);
    rst = 0;
    // resp_i in IDLE must be ignored
    bus.resp_i = 1; bus.burst_i = 64'hFFFFFFFFFFFFFFFF;
    tick();
    chk("idle_ignore_resp", bus.line_o, 256'd0);
    bus.resp_i = 0;
    // read without gaps
    bus.read_i = 1; bus.address_i = 32'h0000_1234;
    tick();
    bus.read_i = 0; bus.address_i = 32'hFFFF_FFFF;
    chk("rd_read_o", 256'(bus.read_o), 256'd1);
    chk("rd_address_o", 256'(bus.address_o), 256'h1220);
    for (int k = 0; k < 4; k++) begin
      chk("rd_no_resp_early", 256'(bus.resp_o), 256'd0);
      beat(b1[k]);
    end
    bus.resp_i = 0;
    chk("rd_resp_o", 256'(bus.resp_o), 256'd1);
    chk("rd_read_o_done", 256'(bus.read_o), 256'd0);
    chk("rd_line_o", bus.line_o, {b1[3], b1[2], b1[1], b1[0]});
    tick();
    chk("rd_resp_pulse", 256'(bus.resp_o), 256'd0);
    chk("rd_address_hold", 256'(bus.address_o), 256'h1220);
    chk("rd_line_hold", bus.line_o, {b1[3], b1[2], b1[1], b1[0]});
    // read with gaps, garbage data during gaps must not be stored
    bus.read_i = 1; bus.address_i = 32'h0000_4000;
    tick();
    bus.read_i = 0;
    for (int j = 0, k = 0; j < 7; j++) begin
      bus.resp_i  = gap_pat[j];
      bus.burst_i = gap_pat[j] ? b2[k] : 64'hDEADBEEFDEADBEEF;
      if (gap_pat[j]) k++;
      tick();
      chk("gap_resp_o", 256'(bus.resp_o), 256'(j == 6));
      chk("gap_read_o", 256'(bus.read_o), 256'(j != 6));
    end
    bus.resp_i = 0;
    chk("gap_line_o", bus.line_o, {b2[3], b2[2], b2[1], b2[0]});
    tick();
    chk("gap_resp_end", 256'(bus.resp_o), 256'd0);
    // write back
    bus.write_i = 1; bus.address_i = 32'h8000_0040; bus.line_i = {d[3], d[2], d[1], d[0]};
    tick();
    bus.write_i = 0; bus.line_i = '1;
    chk("wr_write_o", 256'(bus.write_o), 256'd1);
    chk("wr_read_o", 256'(bus.read_o), 256'd0);
    chk("wr_address_o", 256'(bus.address_o), 256'h8000_0040);
    for (int k = 0; k < 4; k++) begin
      chk("wr_burst_o", 256'(bus.burst_o), 256'(d[k]));
      chk("wr_write_hi", 256'(bus.write_o), 256'd1);
      beat(64'd0);
    end
    bus.resp_i = 0;
    chk("wr_resp_o", 256'(bus.resp_o), 256'd1);
    chk("wr_write_lo", 256'(bus.write_o), 256'd0);
    chk("wr_line_untouched", bus.line_o, {b2[3], b2[2], b2[1], b2[0]});
    tick();
    chk("wr_resp_end", 256'(bus.resp_o), 256'd0);
    // read_i held through DONE must not retrigger
    bus.read_i = 1; bus.address_i = 32'h0000_2000;
    tick();
    for (int k = 0; k < 4; k++) beat(b1[k]);
    bus.resp_i = 0;
    chk("hold_resp_o", 256'(bus.resp_o), 256'd1);
    tick();
    bus.read_i = 0;
    chk("hold_idle_read_o", 256'(bus.read_o), 256'd0);
    chk("hold_idle_resp_o", 256'(bus.resp_o), 256'd0);
    tick();
    chk("hold_no_second", 256'(bus.read_o), 256'd0);
    // reset after two beats
    bus.read_i = 1; bus.address_i = 32'h0000_3000;
    tick();
    bus.read_i = 0;
    beat(b2[0]); beat(b2[1]);
    bus.resp_i = 0; rst = 1;
    tick();
    rst = 0;
    chk("mrst_read_o", 256'(bus.read_o), 256'd0);
    chk("mrst_resp_o", 256'(bus.resp_o), 256'd0);
    chk("mrst_address_o", 256'(bus.address_o), 256'd0);
    chk("mrst_line_o", bus.line_o, 256'd0);
    bus.read_i = 1; bus.address_i = 32'h0000_307F;
    tick();
    bus.read_i = 0;
    chk("mrst_addr2", 256'(bus.address_o), 256'h3060);
    for (int k = 0; k < 4; k++) begin
      chk("mrst_no_resp", 256'(bus.resp_o), 256'd0);
      beat(b3[k]);
    end
    bus.resp_i = 0;
    chk("mrst_resp2", 256'(bus.resp_o), 256'd1);
    chk("mrst_line2", bus.line_o, {b3[3], b3[2], b3[1], b3[0]});
    tick();
    // simultaneous read and write: read wins
    bus.read_i = 1; bus.write_i = 1; bus.address_i = 32'h0000_5000; bus.line_i = '0;
    tick();
    bus.read_i = 0; bus.write_i = 0;
    chk("both_read_o", 256'(bus.read_o), 256'd1);
    for (int k = 0; k < 4; k++) begin
      chk("both_write_o", 256'(bus.write_o), 256'd0);
      beat(b1[k]);
    end
    bus.resp_i = 0;
    chk("both_resp_o", 256'(bus.resp_o), 256'd1);
    chk("both_write_done", 256'(bus.write_o), 256'd0);
    chk("both_line_o", bus.line_o, {b1[3], b1[2], b1[1], b1[0]});
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
